// File: rtl/aes_insn_ctrl_pkg.sv
// Shared types and default timing for the AES instruction requester controller.
package aes_insn_ctrl_pkg;

  localparam int unsigned DEF_LD_HOLD = 2;
  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned DEF_CNT_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/aes_insn_ctrl_if.sv
// Request, wrapper-load and response signals between the CPU pipeline, the
// controller and the AES wrapper. The controller is the slave side.
interface aes_insn_ctrl_if;

  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_key;
  logic [127:0] req_text;
  logic         aes_ld;
  logic [127:0] aes_key;
  logic [127:0] aes_text_in;
  logic         aes_done;
  logic [127:0] aes_text_buf;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_text;
  logic         rsp_err;
  logic         busy;

  modport slave (
    input  req_valid, req_key, req_text, aes_done, aes_text_buf, rsp_ready,
    output req_ready, aes_ld, aes_key, aes_text_in, rsp_valid, rsp_text, rsp_err, busy
  );

  modport master (
    output req_valid, req_key, req_text, aes_done, aes_text_buf, rsp_ready,
    input  req_ready, aes_ld, aes_key, aes_text_in, rsp_valid, rsp_text, rsp_err, busy
  );

endinterface

// File: rtl/aes_insn_ctrl_timer.sv
// Clearable saturating up-counter with a terminal-match flag; one instance
// times both the load hold and the wait timeout.
module aes_insn_timer #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_match
);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over count; the counter parks at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_match = (r_cnt == i_term);

endmodule

// File: rtl/aes_insn_ctrl.sv
// Requester-side controller for the AES instruction wrapper: accepts one
// encrypt request, pulses the load level, waits for done or timeout, returns.
module aes_insn_ctrl
  import aes_insn_ctrl_pkg::*;
#(
  parameter int unsigned LD_HOLD = DEF_LD_HOLD,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  aes_insn_ctrl_if.slave io_bus
);

  localparam logic [CNT_W-1:0] LD_TERM = CNT_W'(LD_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_next;
  logic             r_done_seen;
  logic [127:0]     r_key;
  logic [127:0]     r_text;
  logic [127:0]     r_result;
  logic             r_err;
  logic             w_match;
  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic [CNT_W-1:0] w_term;

  aes_insn_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_term  (w_term),
    .o_match (w_match)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A done already caught during LOAD releases WAIT on its first cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (io_bus.req_valid) w_next = ST_LOAD;
      ST_LOAD: if (w_match) w_next = ST_WAIT;
      ST_WAIT: if (io_bus.aes_done || r_done_seen || w_match) w_next = ST_RESP;
      ST_RESP: if (io_bus.rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    io_bus.req_ready = 1'b0;
    io_bus.aes_ld    = 1'b0;
    io_bus.rsp_valid = 1'b0;
    io_bus.busy      = 1'b1;
    w_tmr_clr        = 1'b0;
    w_tmr_en         = 1'b0;
    w_term           = TO_TERM;
    case (r_state)
      ST_IDLE: begin
        io_bus.req_ready = 1'b1;
        io_bus.busy      = 1'b0;
        w_tmr_clr        = io_bus.req_valid;
      end
      ST_LOAD: begin
        io_bus.aes_ld = 1'b1;
        w_term        = LD_TERM;
        w_tmr_en      = 1'b1;
        w_tmr_clr     = w_match;
      end
      ST_WAIT: w_tmr_en = 1'b1;
      ST_RESP: io_bus.rsp_valid = 1'b1;
      default: io_bus.busy = 1'b1;
    endcase
  end

  // Done in IDLE or RESP is stale and must never touch the result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key       <= '0;
      r_text      <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_done_seen <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && io_bus.req_valid) begin
        r_key  <= io_bus.req_key;
        r_text <= io_bus.req_text;
      end
      if (((r_state == ST_LOAD) || (r_state == ST_WAIT)) && io_bus.aes_done) begin
        r_result <= io_bus.aes_text_buf;
        r_err    <= 1'b0;
      end else if ((r_state == ST_WAIT) && !r_done_seen && w_match) begin
        r_result <= '0;
        r_err    <= 1'b1;
      end
      if ((r_state == ST_LOAD) && io_bus.aes_done) begin
        r_done_seen <= 1'b1;
      end else if (r_state == ST_WAIT) begin
        r_done_seen <= 1'b0;
      end
    end
  end

  assign io_bus.aes_key     = r_key;
  assign io_bus.aes_text_in = r_text;
  assign io_bus.rsp_text    = r_result;
  assign io_bus.rsp_err     = r_err;

endmodule

// File: tb/tb_aes_insn_ctrl.sv
// Scoreboard bench for aes_insn_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares them and watches the load level.
module tb_aes_insn_ctrl;

  localparam int LD_HOLD = 2;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [127:0] text;
    logic         err;
    int           rspEdge;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycle;
  int   nChecks;
  int   nPass;
  exp_t expQ[$];
  exp_t curExp;
  bit   haveExp;
  bit   prevValid;
  bit   tracking;
  int   accEdge;
  logic [127:0] expKey;
  logic [127:0] expText;

  aes_insn_ctrl_if bus ();

  aes_insn_ctrl #(
    .LD_HOLD (LD_HOLD),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (7)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    else nPass++;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // d = accept-relative edge at which done is sampled (0 = no done at all)
  function automatic void refModel(input int d, input logic [127:0] b,
                                   output logic [127:0] t, output logic err, output int lat);
    if (d >= 1 && d <= LD_HOLD) begin
      t = b; err = 1'b0; lat = LD_HOLD + 1;
    end else if (d > LD_HOLD && d <= LD_HOLD + TIMEOUT) begin
      t = b; err = 1'b0; lat = d;
    end else begin
      t = '0; err = 1'b1; lat = LD_HOLD + TIMEOUT;
    end
  endfunction

  // Monitor: response scoreboard, held-output checks, load-level shape and operand stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
      haveExp   = 1'b0;
    end else begin
      if (bus.rsp_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedRsp", 1, 0);
        end else begin
          curExp  = expQ.pop_front();
          haveExp = 1'b1;
          checkOutput("rspCycle", cycle, curExp.rspEdge);
        end
      end
      if (bus.rsp_valid && haveExp) begin
        checkOutput("rspText", bus.rsp_text, curExp.text);
        checkOutput("rspErr", bus.rsp_err, curExp.err);
        checkOutput("reqReadyInResp", bus.req_ready, 0);
      end
      if (!bus.rsp_valid) haveExp = 1'b0;
      prevValid = bus.rsp_valid;
      if (tracking && cycle >= accEdge) begin
        checkOutput("aesLd", bus.aes_ld, (cycle <= accEdge + LD_HOLD - 1));
        checkOutput("aesKeyStable", bus.aes_key, expKey);
        checkOutput("aesTextStable", bus.aes_text_in, expText);
      end else if (!tracking) begin
        checkOutput("aesLdIdle", bus.aes_ld, 0);
      end
    end
  end

  // Called and returning just after a negedge; hsEdge is the handshake (or reset) edge.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] text,
                               input logic [127:0] bufv, input int d, input int hold,
                               input int abortAt, output int hsEdge);
    exp_t e;
    logic [127:0] eText;
    logic eErr;
    int lat;
    int waitN;
    refModel(d, bufv, eText, eErr, lat);
    hsEdge = cycle;
    bus.rsp_ready = (hold == 0);
    bus.req_key   = key;
    bus.req_text  = text;
    bus.req_valid = 1'b1;
    waitN = 0;
    while (!bus.req_ready && waitN < 200) begin
      @(negedge clk);
      waitN++;
    end
    if (!bus.req_ready) begin
      checkOutput("reqAccept", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    accEdge   = cycle + 1;
    expKey    = key;
    expText   = text;
    tracking  = 1'b1;
    e.text    = eText;
    e.err     = eErr;
    e.rspEdge = accEdge + lat;
    expQ.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_key   = rand128();
    bus.req_text  = rand128();
    for (int n = 0; n < LD_HOLD + TIMEOUT + 20; n++) begin
      if (bus.rsp_valid) break;
      if (abortAt > 0 && cycle == accEdge + abortAt) begin
        rst_n        = 1'b0;
        tracking     = 1'b0;
        bus.aes_done = 1'b0;
        expQ.delete();
        #1;
        checkOutput("rstAesLd", bus.aes_ld, 0);
        checkOutput("rstRspValid", bus.rsp_valid, 0);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstReqReady", bus.req_ready, 1);
        @(negedge clk);
        rst_n  = 1'b1;
        hsEdge = cycle;
        return;
      end
      bus.aes_done     = (d > 0) && (cycle == accEdge + d - 1);
      bus.aes_text_buf = bus.aes_done ? bufv : rand128();
      @(negedge clk);
    end
    bus.aes_done = 1'b0;
    if (!bus.rsp_valid) begin
      checkOutput("rspArrive", 0, 1);
      tracking = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_key   = rand128();
      checkOutput("reqReadyBusy", bus.req_ready, 0);
      checkOutput("busyInResp", bus.busy, 1);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    hsEdge = cycle;
    checkOutput("rspCleared", bus.rsp_valid, 0);
    tracking = 1'b0;
  endtask

  initial begin
    int hs;
    int hs2;
    nChecks          = 0;
    nPass            = 0;
    tracking         = 1'b0;
    accEdge          = 0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_key      = '0;
    bus.req_text     = '0;
    bus.aes_done     = 1'b0;
    bus.aes_text_buf = '0;
    bus.rsp_ready    = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetReqReady", bus.req_ready, 1);
    checkOutput("resetAesLd", bus.aes_ld, 0);
    checkOutput("resetRspValid", bus.rsp_valid, 0);
    checkOutput("resetRspErr", bus.rsp_err, 0);
    checkOutput("resetRspText", bus.rsp_text, 0);
    checkOutput("resetAesKey", bus.aes_key, 0);
    checkOutput("resetAesText", bus.aes_text_in, 0);
    checkOutput("resetBusy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] known-answer request");
    applyStimulus(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, LD_HOLD + 13, 0, 0, hs);

    $display("[TB] timeout then late done in IDLE");
    applyStimulus(rand128(), rand128(), rand128(), 0, 0, 0, hs);
    bus.aes_done     = 1'b1;
    bus.aes_text_buf = rand128();
    @(negedge clk);
    bus.aes_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("lateDoneValid", bus.rsp_valid, 0);
      checkOutput("lateDoneText", bus.rsp_text, 0);
      checkOutput("lateDoneErr", bus.rsp_err, 1);
      checkOutput("lateDoneBusy", bus.busy, 0);
      @(negedge clk);
    end

    $display("[TB] back-pressure and back-to-back");
    applyStimulus(rand128(), rand128(), rand128(), LD_HOLD + 4, 5, 0, hs);
    applyStimulus(rand128(), rand128(), rand128(), LD_HOLD + 2, 0, 0, hs2);
    checkOutput("backToBack", accEdge, hs + 1);

    $display("[TB] done and timeout together, done during LOAD");
    applyStimulus(rand128(), rand128(), rand128(), LD_HOLD + TIMEOUT, 0, 0, hs);
    applyStimulus(rand128(), rand128(), rand128(), LD_HOLD + TIMEOUT + 1, 0, 0, hs);
    applyStimulus(rand128(), rand128(), rand128(), 1, 0, 0, hs);
    applyStimulus(rand128(), rand128(), rand128(), LD_HOLD, 1, 0, hs);

    $display("[TB] reset during WAIT, then normal request");
    applyStimulus(rand128(), rand128(), rand128(), 0, 0, LD_HOLD + 5, hs);
    applyStimulus(rand128(), rand128(), rand128(), LD_HOLD + 3, 0, 0, hs);

    $display("[TB] randomized requests");
    for (int r = 0; r < 10; r++) begin
      applyStimulus(rand128(), rand128(), rand128(),
                    $urandom_range(0, LD_HOLD + TIMEOUT + 3), $urandom_range(0, 2), 0, hs);
    end

    repeat (2) @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
